// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC ownership, single-outstanding imem reads, held delivery
`timescale 1ns/1ps
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCsrc,
    input  logic [31:0] PCtarget
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rst_q;
    logic        r_drop;
    logic        w_drop_next;
    logic        w_capture;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] w_target;
    logic        w_unused;

    assign w_target = {PCtarget[31:2], 2'b00};
    assign w_unused = ^PCtarget[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ISSUE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_rst_q holds the first post-reset cycle idle so imem_req is purely registered
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_drop_next  = r_drop;
        w_capture    = 1'b0;
        if (r_rst_q) begin
            if (PCsrc) begin
                w_pc_next = w_target;
            end
        end else begin
            case (r_state)
                ISSUE: begin
                    w_state_next = WAIT;
                    if (PCsrc) begin
                        w_pc_next   = w_target;
                        w_drop_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (PCsrc) begin
                        w_pc_next = w_target;
                        if (imem_rvalid) begin
                            w_state_next = ISSUE;
                            w_drop_next  = 1'b0;
                        end else begin
                            w_drop_next = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        w_state_next = r_drop ? ISSUE : HOLD;
                        w_capture    = ~r_drop;
                        w_drop_next  = 1'b0;
                    end
                end
                HOLD: begin
                    if (PCsrc) begin
                        w_pc_next    = w_target;
                        w_state_next = ISSUE;
                    end else if (instr_ready) begin
                        w_pc_next    = r_pc + 32'd4;
                        w_state_next = ISSUE;
                    end
                end
                default: w_state_next = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q    <= 1'b1;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
        end else begin
            r_rst_q <= 1'b0;
            r_pc    <= w_pc_next;
            r_drop  <= w_drop_next;
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    always_comb begin
        imem_req    = (r_state == ISSUE) && !r_rst_q;
        instr_valid = (r_state == HOLD);
    end

    assign imem_addr = r_pc;
    assign Instr     = r_instr;
    assign PC        = r_instr_pc;
    assign PCPlus4   = r_instr_pc + 32'd4;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter, issues word reads to instruction memory, and presents each fetched instruction on `Instr` to the downstream control/decode logic. It consumes the branch decision (`PCsrc`) and target address from the execute side to redirect fetch, and squashes any in-flight or held instruction on redirect. At most one memory request is outstanding, and delivered instructions are held stable under back-pressure.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `imem_req`  out  1  read request. Memory always accepts it; there is no grant.
- `imem_addr`  out  32  word-aligned read address, valid while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid. Arrives ≥1 cycle after the request, one response per request.
- `imem_rdata`  in  32  read data, valid when `imem_rvalid`=1.
- `Instr`  out  32  delivered instruction (to control/decode).
- `PC`  out  32  address of `Instr`.
- `PCPlus4`  out  32  `PC`+4, modulo 2^32.
- `instr_valid`  out  1  `Instr`/`PC` are valid.
- `instr_ready`  in  1  consumer accepts `Instr` this cycle.
- `PCsrc`  in  1  redirect request (taken branch/jump).
- `PCtarget`  in  32  redirect address. Bits [1:0] are ignored and forced to 0.

## Operation
- Internal state: `pc_q` (32), `state` ∈ {ISSUE, WAIT, HOLD}, `drop_q` (1), `instr_q` (32), `instr_pc_q` (32).
- Reset (`rst`=1 at an edge): `pc_q`=RESET_PC, `state`=ISSUE, `drop_q`=0, `instr_q`=0, `instr_pc_q`=0.
  - Outputs while in reset and in the first cycle after it: `imem_req`=0 during reset, `instr_valid`=0, `Instr`=0, `PC`=0, `PCPlus4`=4.
- ISSUE: `imem_req`=1, `imem_addr`=`pc_q`, `instr_valid`=0. Next state is WAIT.
- WAIT: `imem_req`=0, `instr_valid`=0.
  - `imem_rvalid`=1 and `drop_q`=0: capture `instr_q`=`imem_rdata` and `instr_pc_q`=`pc_q`; next state is HOLD.
  - `imem_rvalid`=1 and `drop_q`=1: discard the data, clear `drop_q`; next state is ISSUE (`pc_q` already holds the redirect target).
- HOLD: `instr_valid`=1; `Instr`, `PC` and `PCPlus4` come from registers and are stable.
  - `instr_ready`=1: `pc_q`=`pc_q`+4 (wraps at 2^32); next state is ISSUE.
- Redirect (`PCsrc`=1) has priority over every other event in every state:
  - `pc_q` = {`PCtarget`[31:2], 2'b00}.
  - ISSUE: the request to the old `pc_q` still goes out this cycle. Next state is WAIT with `drop_q`=1.
  - WAIT, no `imem_rvalid` this cycle: set `drop_q`=1, stay in WAIT.
  - WAIT, with `imem_rvalid` this cycle: discard the data; next state is ISSUE with `drop_q`=0.
  - HOLD: the held instruction is squashed whether or not `instr_ready`=1; next state is ISSUE.
  - The +4 increment never applies in a redirect cycle.
- `imem_rvalid` in ISSUE or HOLD is a protocol violation. It is ignored and has no state effect.
- `rst` has priority over `PCsrc`. A reset mid-WAIT abandons the outstanding request. The memory is reset on the same `rst`, so no stale response follows.

## Timing
- All outputs are registered or decoded from `state` only; there are no combinational paths from inputs to outputs.
- Memory latency L ≥ 1 cycles from request to `imem_rvalid`.
- Fetch-to-deliver latency: request in cycle t, `instr_valid`=1 in cycle t+L+1.
- Peak throughput with L=1 and `instr_ready` held at 1: one instruction per 3 cycles (ISSUE, WAIT, HOLD).
- Redirect penalty:
  - From HOLD: the next request goes out one cycle after `PCsrc`.
  - From ISSUE or WAIT: the next request goes out one cycle after the pending response is dropped.
- `instr_valid` falls in the cycle after acceptance or redirect; it never drops without one of the two.

## Test plan
- Reset release, RESET_PC=0, L=1, memory returns 32'h00500093 at address 0: cycle 1 `imem_req`=1, `imem_addr`=0; cycle 3 `instr_valid`=1, `Instr`=32'h00500093, `PC`=0, `PCPlus4`=4; with `instr_ready`=1, cycle 4 `imem_addr`=4.
- Back-pressure: `instr_ready`=0 for 5 cycles in HOLD. `Instr`/`PC` stay constant, `imem_req` stays 0; on `instr_ready`=1 the next fetch address is `PC`+4.
- Redirect in HOLD: `PCsrc`=1, `PCtarget`=32'h40, `instr_ready`=1 in the same cycle. Next cycle `instr_valid`=0 and `imem_addr`=32'h40; the held instruction is never counted as accepted.
- Redirect in WAIT, L=3: `PCsrc`=1, `PCtarget`=32'h80 one cycle after the request. The stale response is dropped with no `instr_valid`; the next request is to 32'h80 and the delivered `PC`=32'h80.
- Redirect coincident with `imem_rvalid`, and misaligned target: `PCtarget`=32'h42. The data is discarded; next cycle `imem_addr`=32'h40.
- PC wrap, RESET_PC=32'hFFFF_FFFC: after acceptance, the next `imem_addr`=0. Also check: reset asserted mid-WAIT returns to `imem_addr`=RESET_PC with `instr_valid`=0, and a spurious `imem_rvalid` in HOLD leaves `Instr` unchanged.
